// File: rtl/ctrl_pipe_pkg.sv
// Shared constants for the control-signal pipeline: control bundle field
// positions and default geometry.
package ctrl_pipe_pkg;

    localparam int MEMTOREG    = 0;
    localparam int MEMWRITE    = 1;
    localparam int ALUSRC      = 2;
    localparam int REGDST      = 3;
    localparam int REGWRITE    = 4;
    localparam int ALUCTRL_LSB = 5;
    localparam int ALUCTRL_MSB = 7;
    localparam int HILODST     = 8;
    localparam int HILOWRITE   = 9;
    localparam int HILOREAD    = 10;
    localparam int DIV         = 13;

    localparam int CTRL_W_DEFAULT    = 14;
    localparam int MC_CYCLES_DEFAULT = 32;

endpackage

// File: rtl/ctrl_pipe_stage_reg.sv
// One pipeline stage register: {valid, ctrl} with clear, hold and bubble
// select. Clear beats hold, hold beats bubble, bubble beats load.
module ctrl_stage_reg #(
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             hold,
    input  logic             bubble,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q, data_d;

    // NOTE: a default-first assignment in always_comb prevents latch inference.
    always_comb begin
        data_d = data_q;
        if (clear)       data_d = '0;
        else if (hold)   data_d = data_q;
        else if (bubble) data_d = '0;
        else             data_d = d;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) data_q <= '0;
        else      data_q <= data_d;
    end

    assign q = data_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Control bundle pipeline from decode through NSTG stages, with a per-stage
// hold chain and a multi-cycle interlock that pins stage 0 for divides.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int W         = CTRL_W_DEFAULT,
    parameter int NSTG      = 3,
    parameter int MC_BIT    = DIV,
    parameter int MC_CYCLES = MC_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      in_ctrl,
    input  logic              in_valid,
    input  logic [NSTG-1:0]   stall,
    input  logic [NSTG-1:0]   flush,
    output logic [NSTG*W-1:0] stage_ctrl,
    output logic [NSTG-1:0]   stage_valid,
    output logic              stall_up,
    output logic              mc_busy
);

    localparam int CW = $clog2(MC_CYCLES) + 1;

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NSTG-1:0] hold;
    logic            acc;
    logic            mc_load;
    logic [W:0]      stage_q [NSTG];

    assign mc_busy  = (cnt_q != '0);
    assign stall_up = hold[0];

    // A stall anywhere downstream propagates back to every earlier stage.
    always_comb begin
        acc  = 1'b0;
        hold = '0;
        for (int k = NSTG - 1; k >= 0; k--) begin
            acc     = acc | stall[k];
            hold[k] = acc;
        end
        hold[0] = acc | mc_busy;
    end

    assign mc_load = !flush[0] && !hold[0] && in_valid && in_ctrl[MC_BIT]
                     && (MC_CYCLES > 1);

    always_comb begin
        cnt_d = cnt_q;
        if (flush[0])          cnt_d = '0;
        else if (mc_load)      cnt_d = CW'(MC_CYCLES - 1);
        else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        if (k == 0) begin : g_head
            // Invalid decode slots enter as all-zero so no stray write enables leak.
            ctrl_stage_reg #(.WIDTH(W + 1)) u_reg (
                .clk    (clk),
                .rst    (rst),
                .clear  (flush[0]),
                .hold   (hold[0]),
                .bubble (1'b0),
                .d      ({in_valid, in_valid ? in_ctrl : {W{1'b0}}}),
                .q      (stage_q[0])
            );
        end else begin : g_body
            ctrl_stage_reg #(.WIDTH(W + 1)) u_reg (
                .clk    (clk),
                .rst    (rst),
                .clear  (flush[k]),
                .hold   (hold[k]),
                .bubble (hold[k-1]),
                .d      (stage_q[k-1]),
                .q      (stage_q[k])
            );
        end
        assign stage_ctrl[k*W +: W] = stage_q[k][W-1:0];
        assign stage_valid[k]       = stage_q[k][W];
    end

endmodule
